// File: rtl/bus8085_pkg.sv
// Shared state encodings, S1/S0 status codes and defaults for the 8085-style bus initiator.
package bus8085_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StT1   = 3'd1;
    localparam state_t StT2   = 3'd2;
    localparam state_t StTw   = 3'd3;
    localparam state_t StT3   = 3'd4;

    // {S1, S0} status encodings
    localparam logic [1:0] SIdle  = 2'b00;
    localparam logic [1:0] SRead  = 2'b10;
    localparam logic [1:0] SWrite = 2'b01;

    localparam int unsigned TimeoutCyclesDefault = 16;

endpackage

// File: rtl/bus8085_wait_timer.sv
// Counts TW cycles of one bus cycle; expire_o flags the last tolerated wait state.
module bus8085_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // High during the TIMEOUT_CYCLES-th TW cycle, so that cycle is the last wait state
    assign expire_o = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus8085_initiator.sv
// 8085-style multiplexed bus initiator (T1/T2/TW/T3). Optional wait-state
// timeout enabled by defining BUS8085_TIMEOUT_EN.
module bus8085_initiator
    import bus8085_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_write,
    input  logic        req_io,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  haddress,
    inout  wire  [7:0]  laddress_data,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        IOMn,
    output logic        S0,
    output logic        S1,
    input  logic        READY
);

    state_t      state_q, state_d;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        write_q;
    logic        io_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        accept;
    logic        tw_abort;
    logic        timed_out;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef BUS8085_TIMEOUT_EN
    logic tmo_q;

    bus8085_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (state_q == StT2),
        .count_i (state_q == StTw),
        .expire_o(tw_abort)
    );

    logic rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                tmo_q <= 1'b0;
            end else if (state_q == StTw && !READY && tw_abort) begin
                tmo_q <= 1'b1;
            end
            rsp_err_q <= (state_q == StT3) && tmo_q;
        end
    end

    assign timed_out = tmo_q;
    assign rsp_err   = rsp_err_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tw_abort  = 1'b0;
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StT1;
            StT1:    state_d = StT2;
            StT2:    state_d = READY ? StT3 : StTw;
            StTw:    if (READY || tw_abort) state_d = StT3;
            StT3:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_q == StT3);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
                io_q    <= req_io;
            end
            if (state_q == StT3 && timed_out) begin
                rsp_rdata_q <= 8'hFF;
            end else if (state_q == StT3 && !write_q) begin
                rsp_rdata_q <= laddress_data;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Bus pins are a pure decode of the registered state and the captured request
    logic in_cycle, strobe, ad_oe;
    assign in_cycle = (state_q != StIdle);
    assign strobe   = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
    assign ad_oe    = (state_q == StT1) || (strobe && write_q);

    assign ALE      = (state_q == StT1);
    assign haddress = in_cycle ? addr_q[15:8] : 8'h00;
    assign IOMn     = in_cycle && io_q;
    assign {S1, S0} = !in_cycle ? SIdle : (write_q ? SWrite : SRead);
    assign RDn      = !(strobe && !write_q);
    assign WRn      = !(strobe && write_q);

    assign laddress_data = ad_oe ? ((state_q == StT1) ? addr_q[7:0] : wdata_q) : 8'hzz;

endmodule

// File: tb/tb_bus8085_initiator.sv
// Scoreboard bench for bus8085_initiator with a RAM responder on the AD bus.
// Define BUS8085_TIMEOUT_EN to also exercise the wait-state timeout.
module tb_bus8085_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_write;
    logic        req_io;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [7:0]  haddress;
    wire  [7:0]  ad_bus;
    logic        ALE, RDn, WRn, IOMn, S0, S1;
    logic        ready;

    bus8085_initiator dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_write    (req_write),
        .req_io       (req_io),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .haddress     (haddress),
        .laddress_data(ad_bus),
        .ALE          (ALE),
        .RDn          (RDn),
        .WRn          (WRn),
        .IOMn         (IOMn),
        .S0           (S0),
        .S1           (S1),
        .READY        (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM responder: latch address on ALE, drive data while RDn is low
    logic [7:0]  mem [0:65535];
    logic [15:0] lat_addr;
    always @(posedge clk) begin
        if (ALE === 1'b1) lat_addr <= {haddress, ad_bus};
        if (WRn === 1'b0) mem[lat_addr] <= ad_bus;
    end
    assign ad_bus = (RDn === 1'b0) ? mem[lat_addr] : 8'hzz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    // Strobe/ALE pulse-width counters, cleared by the stimulus before each transaction
    int rd_low = 0, wr_low = 0, ale_hi = 0;
    always @(negedge clk) begin
        if (RDn === 1'b0) rd_low++;
        if (WRn === 1'b0) wr_low++;
        if (ALE === 1'b1) ale_hi++;
    end

    exp_t e;
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] wd, input logic w,
                         input logic io, input logic push, input logic [7:0] er,
                         input logic ee, input int waits, output int acc);
        req_addr  = a;
        req_wdata = wd;
        req_write = w;
        req_io    = io;
        req_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept: got no req_ready in 50 cycles, expected acceptance");
        end else if (push) begin
            exp_q.push_back('{er, ee, acc + 4 + waits});
        end
        @(posedge clk);
        #1;
    endtask

    int acc1, acc2;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_write = 1'b0; req_io = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        mem[16'h0105] <= 8'h3C;
        mem[16'h2233] <= 8'h5A;
        mem[16'h0300] <= 8'h77;
        @(negedge clk);
        check("reset_outputs",
              {ALE, RDn, WRn, IOMn, S1, S0, haddress, req_ready, rsp_valid, rsp_err, rsp_rdata},
              {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Memory read 0x0105, zero waits
        @(posedge clk); #1;
        rd_low = 0; wr_low = 0; ale_hi = 0;
        issue(16'h0105, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 0, acc1);
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_t1", {ALE, haddress, ad_bus, S1, S0, IOMn}, {1'b1, 8'h01, 8'h05, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        check("rd_t2", {ALE, RDn, WRn, haddress, S1, S0}, {1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0});
        @(negedge clk);
        check("rd_t3", {RDn, haddress}, {1'b0, 8'h01});
        @(negedge clk);
        check("rd_idle", {RDn, WRn, S1, S0, req_ready}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        check("rd_strobe_width", rd_low, 2);
        check("rd_ale_width", ale_hi, 1);

        // I/O write 0x0042 <= 0xA5
        @(posedge clk); #1;
        rd_low = 0; wr_low = 0;
        issue(16'h0042, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 0, acc1);
        req_valid = 1'b0;
        @(negedge clk);
        check("wr_t1", {IOMn, S1, S0, haddress, ad_bus}, {1'b1, 1'b0, 1'b1, 8'h00, 8'h42});
        @(negedge clk);
        check("wr_t2", {WRn, RDn, ad_bus}, {1'b0, 1'b1, 8'hA5});
        @(negedge clk);
        check("wr_t3", {WRn, ad_bus, IOMn}, {1'b0, 8'hA5, 1'b1});
        @(negedge clk);
        check("wr_strobe_width", wr_low, 2);
        check("wr_no_rd", rd_low, 0);

        // Read 0x2233 with READY low for three samples
        @(posedge clk); #1;
        rd_low = 0; ready = 1'b0;
        issue(16'h2233, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 3, acc1);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tw_hold", {haddress, S1, S0, RDn, ALE}, {8'h22, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1 ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("tw_strobe_width", rd_low, 5);

        // Back-to-back write then read of 0x0000 with req_valid held
        @(posedge clk); #1;
        issue(16'h0000, 8'h11, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 0, acc1);
        issue(16'h0000, 8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 0, acc2);
        req_valid = 1'b0;
        check("b2b_accept_gap", acc2 - acc1, 4);
        repeat (6) @(posedge clk);

        // Reset during TW aborts the read with no response
        #1 ready = 1'b0;
        issue(16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, acc1);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_pre_rdn", {31'h0, RDn}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_strobes", {RDn, WRn, ALE, rsp_valid}, {1'b1, 1'b1, 1'b0, 1'b0});
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("abort_ready", {30'h0, req_ready, rsp_valid}, 32'h2);
        repeat (4) @(posedge clk);

`ifdef BUS8085_TIMEOUT_EN
        // READY stuck low: timeout after 16 TW cycles
        #1 ready = 1'b0;
        issue(16'h0300, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 16, acc1);
        req_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1 ready = 1'b1;
`endif

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
